// File: rtl/trdb_rst_seq_pkg.sv
// Shared types and sizing helpers for the trace-debugger reset sequencer.
package trdb_rst_seq_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      REL,
      RUN,
      DRAIN,
      EOS,
      UNREL
   } trdb_rst_state_e;

   // Index width for an n-entry range, never narrower than one bit.
   function automatic int unsigned trdb_idx_w(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

   localparam int unsigned TRDB_DEF_NUM_CH = 4;
   localparam int unsigned TRDB_CH_IDX_W   = trdb_idx_w(TRDB_DEF_NUM_CH);

endpackage

// File: rtl/trdb_rst_sync.sv
// Reset synchronizer: asynchronous assert, release after SYNC_STAGES clock edges.
module trdb_rst_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic i_clk,
   input  logic i_rst_n,
   output logic o_rst_sync
);

   logic [SYNC_STAGES-1:0] r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
   end

   assign o_rst_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/trdb_rst_sequencer.sv
// Staged channel-reset release, run-cycle counter/timeout and sticky end-of-sim flag.
// Optional reverse re-assertion of channels at end of run: TRDB_RST_SEQ_REVERSE_ASSERT_EN.
module trdb_rst_sequencer
   import trdb_rst_seq_pkg::*;
#(
   parameter int unsigned NUM_CH       = 4,
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned INIT_WAIT    = 5,
   parameter int unsigned GAP          = 3,
   parameter int unsigned DRAIN_CYCLES = 4,
   parameter int unsigned CNT_W        = 32
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              soft_rst_i,
   input  logic [NUM_CH-1:0] hold_i,
   input  logic              eos_req_i,
   input  logic [CNT_W-1:0]  timeout_i,
   output logic [NUM_CH-1:0] rst_no,
   output logic              all_released_o,
   output logic [CNT_W-1:0]  cycle_cnt_o,
   output logic              eos_o,
   output logic              timeout_o
);

   localparam int unsigned CH_W    = trdb_idx_w(NUM_CH);
   localparam int unsigned TMR_MAX = (INIT_WAIT > GAP) ?
                                     ((INIT_WAIT > DRAIN_CYCLES) ? INIT_WAIT : DRAIN_CYCLES) :
                                     ((GAP > DRAIN_CYCLES) ? GAP : DRAIN_CYCLES);
   localparam int unsigned TMR_W   = trdb_idx_w(TMR_MAX);
   localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   trdb_rst_state_e   r_state, w_state_nxt;
   logic [CH_W-1:0]   r_ch, w_ch_nxt;
   logic [TMR_W-1:0]  r_tmr, w_tmr_nxt, w_tmr_eff;
   logic [CNT_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
   logic [NUM_CH-1:0] r_rst_n, w_rst_n_nxt;
   logic              r_eos, w_eos_nxt;
   logic              r_to, w_to_nxt;
   logic              w_rst_sync;
   logic              w_end;

   trdb_rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .i_clk      (clk_i),
      .i_rst_n    (rst_ni),
      .o_rst_sync (w_rst_sync)
   );

   assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);
   // Leaving IDLE is the first edge after the synchronizer releases, so one wait cycle is already spent.
   assign w_tmr_eff = (r_state == IDLE) ? TMR_W'(INIT_WAIT - 1) : r_tmr;

   always_comb begin
      w_state_nxt = r_state;
      w_ch_nxt    = r_ch;
      w_tmr_nxt   = r_tmr;
      w_cnt_nxt   = r_cnt;
      w_rst_n_nxt = r_rst_n;
      w_eos_nxt   = r_eos;
      w_to_nxt    = r_to;
      w_end       = 1'b0;

      if (soft_rst_i && (r_state inside {WAIT, REL, RUN, DRAIN})) begin
         w_state_nxt = WAIT;
         w_rst_n_nxt = '0;
         w_cnt_nxt   = '0;
         w_ch_nxt    = '0;
         w_tmr_nxt   = TMR_W'(INIT_WAIT - 1);
      end else begin
         case (r_state)
            IDLE, WAIT, REL: begin
               if ((r_state != IDLE) || w_rst_sync) begin
                  if (r_state == IDLE) w_state_nxt = WAIT;
                  if (w_tmr_eff != '0) begin
                     w_tmr_nxt = w_tmr_eff - TMR_W'(1);
                  end else if (!hold_i[r_ch]) begin
                     w_rst_n_nxt[r_ch] = 1'b1;
                     if (r_ch == LAST_CH) begin
                        w_state_nxt = RUN;
                     end else begin
                        w_state_nxt = REL;
                        w_ch_nxt    = r_ch + CH_W'(1);
                        w_tmr_nxt   = TMR_W'(GAP - 1);
                     end
                  end else begin
                     w_tmr_nxt = '0;
                  end
               end
            end
            RUN: begin
               w_cnt_nxt = w_cnt_inc;
               if ((timeout_i != '0) && (w_cnt_inc == timeout_i)) begin
                  w_to_nxt = 1'b1;
                  w_end    = 1'b1;
               end else if (eos_req_i) begin
                  w_state_nxt = DRAIN;
                  w_tmr_nxt   = TMR_W'(DRAIN_CYCLES - 1);
               end
            end
            DRAIN: begin
               if (r_tmr == '0) w_end = 1'b1;
               else             w_tmr_nxt = r_tmr - TMR_W'(1);
            end
            UNREL: begin
               if (r_tmr != '0) begin
                  w_tmr_nxt = r_tmr - TMR_W'(1);
               end else begin
                  w_rst_n_nxt[r_ch] = 1'b0;
                  if (r_ch == '0) begin
                     w_state_nxt = EOS;
                     w_eos_nxt   = 1'b1;
                  end else begin
                     w_ch_nxt  = r_ch - CH_W'(1);
                     w_tmr_nxt = TMR_W'(GAP - 1);
                  end
               end
            end
            default: ;
         endcase

`ifdef TRDB_RST_SEQ_REVERSE_ASSERT_EN
         // Highest channel drops on entry; the rest follow GAP apart, eos on channel 0.
         if (w_end) begin
            w_rst_n_nxt[NUM_CH-1] = 1'b0;
            if (NUM_CH == 1) begin
               w_state_nxt = EOS;
               w_eos_nxt   = 1'b1;
            end else begin
               w_state_nxt = UNREL;
               w_ch_nxt    = CH_W'((NUM_CH > 1) ? NUM_CH - 2 : 0);
               w_tmr_nxt   = TMR_W'(GAP - 1);
            end
         end
`else
         if (w_end) begin
            w_state_nxt = EOS;
            w_eos_nxt   = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state <= IDLE;
         r_ch    <= '0;
         r_tmr   <= '0;
         r_cnt   <= '0;
         r_rst_n <= '0;
         r_eos   <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ch    <= w_ch_nxt;
         r_tmr   <= w_tmr_nxt;
         r_cnt   <= w_cnt_nxt;
         r_rst_n <= w_rst_n_nxt;
         r_eos   <= w_eos_nxt;
         r_to    <= w_to_nxt;
      end
   end

   assign rst_no         = r_rst_n;
   assign all_released_o = (r_state == RUN);
   assign cycle_cnt_o    = r_cnt;
   assign eos_o          = r_eos;
   assign timeout_o      = r_to;

endmodule

// File: tb/tb_trdb_rst_sequencer.sv
// Directed bench for trdb_rst_sequencer; posedge k is counted from the rst_ni rise.
module tb_trdb_rst_sequencer;

   localparam int NUM_CH = 4;
   localparam int CNT_W  = 4;

   logic              clk_i = 1'b0;
   logic              rst_ni = 1'b1;
   logic              soft_rst_i = 1'b0;
   logic [NUM_CH-1:0] hold_i = '0;
   logic              eos_req_i = 1'b0;
   logic [CNT_W-1:0]  timeout_i = '0;
   logic [NUM_CH-1:0] rst_no;
   logic              all_released_o;
   logic [CNT_W-1:0]  cycle_cnt_o;
   logic              eos_o;
   logic              timeout_o;

   int n_vec = 0;
   int n_err = 0;
   int k = 0;

   trdb_rst_sequencer #(
      .NUM_CH(NUM_CH), .SYNC_STAGES(2), .INIT_WAIT(5), .GAP(3),
      .DRAIN_CYCLES(4), .CNT_W(CNT_W)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .soft_rst_i     (soft_rst_i),
      .hold_i         (hold_i),
      .eos_req_i      (eos_req_i),
      .timeout_i      (timeout_i),
      .rst_no         (rst_no),
      .all_released_o (all_released_o),
      .cycle_cnt_o    (cycle_cnt_o),
      .eos_o          (eos_o),
      .timeout_o      (timeout_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #100000;
      $display("FAIL watchdog: sim time limit reached at k=%0d", k);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      k++;
      #1;
   endtask

   task automatic run_to(input int t);
      while (k < t) tick();
   endtask

   task automatic do_reset();
      rst_ni = 1'b0; soft_rst_i = 1'b0; eos_req_i = 1'b0; hold_i = '0;
      #3;
      @(negedge clk_i);
      rst_ni = 1'b1;
      k = 0;
   endtask

   task automatic test_reset();
      #2 rst_ni = 1'b0;
      #1;
      n_vec++; if (rst_no !== 4'b0000) begin n_err++; $display("FAIL reset_rst_no got=%b exp=0000", rst_no); end
      n_vec++; if (all_released_o !== 1'b0) begin n_err++; $display("FAIL reset_all_rel got=%b exp=0", all_released_o); end
      n_vec++; if (cycle_cnt_o !== 4'd0) begin n_err++; $display("FAIL reset_cnt got=%0d exp=0", cycle_cnt_o); end
      n_vec++; if (eos_o !== 1'b0) begin n_err++; $display("FAIL reset_eos got=%b exp=0", eos_o); end
      n_vec++; if (timeout_o !== 1'b0) begin n_err++; $display("FAIL reset_to got=%b exp=0", timeout_o); end
   endtask

   task automatic test_release();
      logic [NUM_CH-1:0] e;
      do_reset();
      for (int t = 1; t <= 17; t++) begin
         tick();
         for (int i = 0; i < NUM_CH; i++) e[i] = (k >= 7 + 3*i);
         n_vec++; if (rst_no !== e) begin n_err++; $display("FAIL rel_rst_no k=%0d got=%b exp=%b", k, rst_no, e); end
         n_vec++; if (all_released_o !== (k >= 16)) begin n_err++; $display("FAIL rel_all k=%0d got=%b exp=%b", k, all_released_o, k >= 16); end
      end
      n_vec++; if (cycle_cnt_o !== 4'd1) begin n_err++; $display("FAIL rel_cnt17 got=%0d exp=1", cycle_cnt_o); end
   endtask

   task automatic test_hold();
      logic [NUM_CH-1:0] e;
      do_reset();
      hold_i = 4'b0100;
      for (int t = 1; t <= 24; t++) begin
         tick();
         if (k == 19) hold_i = 4'b0000;
         e[0] = (k >= 7); e[1] = (k >= 10); e[2] = (k >= 20); e[3] = (k >= 23);
         n_vec++; if (rst_no !== e) begin n_err++; $display("FAIL hold_rst_no k=%0d got=%b exp=%b", k, rst_no, e); end
         n_vec++; if (all_released_o !== (k >= 23)) begin n_err++; $display("FAIL hold_all k=%0d got=%b exp=%b", k, all_released_o, k >= 23); end
      end
      hold_i = 4'b1111;
      run_to(27);
      n_vec++; if (rst_no !== 4'b1111) begin n_err++; $display("FAIL hold_after_rel got=%b exp=1111", rst_no); end
      hold_i = '0;
   endtask

   task automatic test_timeout();
      do_reset();
      timeout_i = 4'd10;
      run_to(25);
      n_vec++; if (cycle_cnt_o !== 4'd9 || eos_o !== 1'b0) begin n_err++; $display("FAIL to_pre cnt=%0d eos=%b exp cnt=9 eos=0", cycle_cnt_o, eos_o); end
      tick();
      n_vec++; if (cycle_cnt_o !== 4'd10) begin n_err++; $display("FAIL to_cnt got=%0d exp=10", cycle_cnt_o); end
      n_vec++; if (eos_o !== 1'b1 || timeout_o !== 1'b1) begin n_err++; $display("FAIL to_flags eos=%b to=%b exp 1 1", eos_o, timeout_o); end
      n_vec++; if (all_released_o !== 1'b0) begin n_err++; $display("FAIL to_all got=%b exp=0", all_released_o); end
      run_to(31);
      n_vec++; if (cycle_cnt_o !== 4'd10 || eos_o !== 1'b1) begin n_err++; $display("FAIL to_frozen cnt=%0d eos=%b exp 10 1", cycle_cnt_o, eos_o); end
      n_vec++; if (rst_no !== 4'b1111) begin n_err++; $display("FAIL to_rst_no got=%b exp=1111", rst_no); end
      timeout_i = '0;
   endtask

   task automatic test_eos_req();
      do_reset();
      timeout_i = '0;
      eos_req_i = 1'b1;
      run_to(12);
      eos_req_i = 1'b0;
      run_to(16);
      n_vec++; if (all_released_o !== 1'b1 || rst_no !== 4'b1111) begin n_err++; $display("FAIL eos_ignored_rel all=%b rst=%b exp 1 1111", all_released_o, rst_no); end
      run_to(20);
      n_vec++; if (cycle_cnt_o !== 4'd4) begin n_err++; $display("FAIL eos_cnt20 got=%0d exp=4", cycle_cnt_o); end
      eos_req_i = 1'b1;
      tick();
      eos_req_i = 1'b0;
      n_vec++; if (cycle_cnt_o !== 4'd5 || all_released_o !== 1'b0 || eos_o !== 1'b0) begin n_err++; $display("FAIL eos_drain_entry cnt=%0d all=%b eos=%b exp 5 0 0", cycle_cnt_o, all_released_o, eos_o); end
      run_to(24);
      n_vec++; if (eos_o !== 1'b0) begin n_err++; $display("FAIL eos_early got=%b exp=0", eos_o); end
      tick();
      n_vec++; if (eos_o !== 1'b1 || timeout_o !== 1'b0) begin n_err++; $display("FAIL eos_done eos=%b to=%b exp 1 0", eos_o, timeout_o); end
      n_vec++; if (cycle_cnt_o !== 4'd5 || rst_no !== 4'b1111) begin n_err++; $display("FAIL eos_hold cnt=%0d rst=%b exp 5 1111", cycle_cnt_o, rst_no); end
      soft_rst_i = 1'b1;
      tick();
      soft_rst_i = 1'b0;
      n_vec++; if (rst_no !== 4'b1111 || eos_o !== 1'b1 || cycle_cnt_o !== 4'd5) begin n_err++; $display("FAIL eos_soft_ignored rst=%b eos=%b cnt=%0d exp 1111 1 5", rst_no, eos_o, cycle_cnt_o); end
   endtask

   task automatic test_soft_rst();
      logic [NUM_CH-1:0] e;
      do_reset();
      run_to(20);
      soft_rst_i = 1'b1; eos_req_i = 1'b1;
      tick();
      soft_rst_i = 1'b0; eos_req_i = 1'b0;
      n_vec++; if (rst_no !== 4'b0000 || all_released_o !== 1'b0 || cycle_cnt_o !== 4'd0) begin n_err++; $display("FAIL soft_clear rst=%b all=%b cnt=%0d exp 0000 0 0", rst_no, all_released_o, cycle_cnt_o); end
      for (int t = 22; t <= 36; t++) begin
         tick();
         for (int i = 0; i < NUM_CH; i++) e[i] = (k >= 26 + 3*i);
         n_vec++; if (rst_no !== e) begin n_err++; $display("FAIL soft_rel k=%0d got=%b exp=%b", k, rst_no, e); end
         n_vec++; if (eos_o !== 1'b0) begin n_err++; $display("FAIL soft_eos k=%0d got=%b exp=0", k, eos_o); end
      end
      n_vec++; if (all_released_o !== 1'b1 || cycle_cnt_o !== 4'd1) begin n_err++; $display("FAIL soft_run all=%b cnt=%0d exp 1 1", all_released_o, cycle_cnt_o); end
   endtask

   task automatic test_async_mid();
      logic [NUM_CH-1:0] e;
      do_reset();
      run_to(11);
      n_vec++; if (rst_no !== 4'b0011) begin n_err++; $display("FAIL async_pre got=%b exp=0011", rst_no); end
      #3 rst_ni = 1'b0;
      #1;
      n_vec++; if (rst_no !== 4'b0000 || all_released_o !== 1'b0 || eos_o !== 1'b0) begin n_err++; $display("FAIL async_clear rst=%b all=%b eos=%b exp 0000 0 0", rst_no, all_released_o, eos_o); end
      @(negedge clk_i);
      rst_ni = 1'b1;
      k = 0;
      for (int t = 1; t <= 16; t++) begin
         tick();
         for (int i = 0; i < NUM_CH; i++) e[i] = (k >= 7 + 3*i);
         n_vec++; if (rst_no !== e) begin n_err++; $display("FAIL async_rel k=%0d got=%b exp=%b", k, rst_no, e); end
      end
      n_vec++; if (all_released_o !== 1'b1) begin n_err++; $display("FAIL async_all got=%b exp=1", all_released_o); end
   endtask

   task automatic test_saturate();
      do_reset();
      timeout_i = '0;
      run_to(30);
      n_vec++; if (cycle_cnt_o !== 4'd14) begin n_err++; $display("FAIL sat_pre got=%0d exp=14", cycle_cnt_o); end
      run_to(31);
      n_vec++; if (cycle_cnt_o !== 4'd15) begin n_err++; $display("FAIL sat_max got=%0d exp=15", cycle_cnt_o); end
      run_to(36);
      n_vec++; if (cycle_cnt_o !== 4'd15 || all_released_o !== 1'b1 || eos_o !== 1'b0) begin n_err++; $display("FAIL sat_hold cnt=%0d all=%b eos=%b exp 15 1 0", cycle_cnt_o, all_released_o, eos_o); end
   endtask

   initial begin
      test_reset();
      test_release();
      test_hold();
      test_timeout();
      test_eos_req();
      test_soft_rst();
      test_async_mid();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
